// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
// Optional signed-overflow output is enabled with SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder; the per-cycle arithmetic cell of serial_adder.
module full_adder_bit
   import serial_adder_pkg::*;
(
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_co
);

   assign o_s  = i_a ^ i_b ^ i_c;
   assign o_co = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: {cout,sum} = a + b + cin over WIDTH clocks.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output o_ovf.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a_in,
   input  logic [WIDTH-1:0] i_b_in,
   input  logic             i_cin,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout
`ifdef SERIAL_ADDER_OVF_EN
  ,output logic             o_ovf
`endif
);

   localparam int unsigned      CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-2:0] r_s_sr;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic             r_ovf;
`endif

   logic             w_s;
   logic             w_co;
   logic [WIDTH-1:0] w_shift;

   full_adder_bit u_cell (
      .i_a  (r_a_sr[0]),
      .i_b  (r_b_sr[0]),
      .i_c  (r_carry),
      .o_s  (w_s),
      .o_co (w_co)
   );

   // New sum bit enters at the MSB; on the last cycle this is the full result.
   assign w_shift = {w_s, r_s_sr};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a_sr  <= '0;
         r_b_sr  <= '0;
         r_s_sr  <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         r_ovf   <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (i_start) begin
                  r_a_sr  <= i_a_in;
                  r_b_sr  <= i_b_in;
                  r_carry <= i_cin;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ADD;
               end else begin
                  r_state <= IDLE;
               end
            end
            ADD: begin
               r_a_sr  <= r_a_sr >> 1;
               r_b_sr  <= r_b_sr >> 1;
               r_s_sr  <= w_shift[WIDTH-1:1];
               r_carry <= w_co;
               if (r_cnt == LAST) begin
                  r_sum   <= w_shift;
                  r_cout  <= w_co;
`ifdef SERIAL_ADDER_OVF_EN
                  // r_carry here is the carry into the MSB position.
                  r_ovf   <= r_carry ^ w_co;
`endif
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_sum  = r_sum;
   assign o_cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
   assign o_ovf  = r_ovf;
`endif

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder that reuses the one-bit carry-out cell as its arithmetic core and registers the carry between cycles. It loads two WIDTH-bit operands on a start request and adds them LSB-first, one bit per clock. It reports the sum, the final carry-out and a done pulse. It sits directly downstream of the carry-out/full-adder cell and wraps it into a multi-cycle sequential datapath.

## Interface
- WIDTH, 8, operand/sum width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request to begin an add; sampled on rising edge
- a_in  input  WIDTH  operand A, captured when start is accepted
- b_in  input  WIDTH  operand B, captured when start is accepted
- cin  input  1  carry-in, captured when start is accepted
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  registered result; held until the next completion
- cout  output  1  registered final carry-out
- ovf  output  1  signed overflow flag (only with SERIAL_ADDER_OVF_EN)

## Operation
- One clock; reset is asynchronous and active-low.
- FSM states and transitions:
  - IDLE: waiting. start=1 → ADD.
  - ADD: processing bits. When bit counter = WIDTH-1 → DONE.
  - DONE: done=1. start=1 → ADD; otherwise → IDLE.
- On accept (IDLE or DONE with start=1):
  - a_sr ← a_in, b_sr ← b_in
  - carry ← cin, cnt ← 0
- Each ADD cycle:
  - full-adder cell evaluates a_sr[0], b_sr[0], carry.
  - Its sum bit shifts into the MSB of s_sr; a_sr and b_sr shift right.
  - carry ← cell cout; cnt ← cnt+1.
- Last ADD cycle (cnt = WIDTH-1):
  - sum ← completed shift value.
  - cout ← cell cout.
- start while in ADD is ignored; in-flight operands are unaffected.
- Arithmetic is modulo 2^WIDTH plus carry: {cout,sum} = a_in + b_in + cin.
- cnt width is $clog2(WIDTH); it never wraps past WIDTH-1.
- Reset, including mid-operation:
  - state → IDLE; busy, done, sum, cout, ovf → 0; shift registers and cnt → 0.
  - The in-flight operation is aborted and no done is produced.

## Timing
- Start accepted at rising edge T.
- busy is high from edge T to edge T+WIDTH (WIDTH cycles), i.e. busy = (state == ADD).
- sum, cout and ovf update at edge T+WIDTH.
- done is high for exactly one cycle, from edge T+WIDTH to T+WIDTH+1.
- Back-to-back: start held high during the DONE cycle is accepted at edge T+WIDTH+1. Throughput is one add per WIDTH+1 cycles.
- sum and cout stay stable through the next operation's ADD phase and change only at its completion edge.
- No combinational path from inputs to outputs.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - ovf port exists.
  - At the last ADD cycle, ovf ← (carry into the MSB) XOR (cell cout).
  - ovf holds like sum.
- SERIAL_ADDER_OVF_EN not defined:
  - ovf port and its register are absent.
  - All other behaviour is identical.

## Structure
- serial_adder_pkg:
  - state_t enum {IDLE, ADD, DONE}.
  - DEFAULT_WIDTH = 8.
- Sub-module full_adder_bit: combinational a, b, c → s, co, instantiated once as the per-cycle arithmetic cell.
- Top level holds the FSM, shift registers, counter and result registers.

## Test plan
All scenarios use WIDTH=8.
- Basic add:
  - Stimulus: reset released, start with a=0x0F, b=0x01, cin=0.
  - Response: busy for 8 cycles; done one cycle later aligned with sum=0x10, cout=0, ovf=0.
- Full wrap:
  - Stimulus: a=0xFF, b=0x01, cin=0.
  - Response: sum=0x00, cout=1, ovf=0.
  - Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Signed overflow (macro on):
  - Stimulus: a=0x7F, b=0x01, cin=0.
  - Response: sum=0x80, cout=0, ovf=1.
- Ignored start:
  - Stimulus: start a=0x12, b=0x34; pulse start with a=0xAA, b=0x55 on cycle 3 of busy.
  - Response: single done, sum=0x46, cout=0.
- Reset mid-operation:
  - Stimulus: start a=0xF0, b=0x0F; assert rst_n=0 on cycle 4.
  - Response: busy, done, sum, cout all 0 immediately, no done pulse; next add of 0x01+0x01 → sum=0x02.
- Back-to-back:
  - Stimulus: start held high continuously with 0x10+0x20, then 0x80+0x80.
  - Response: done pulses 9 cycles apart; sum=0x30/cout=0, then sum=0x00/cout=1.
